blink_sequencer: RTL
====================

# blink_sequencer

Programmable blink-pattern controller that sequences the LED blink output from the shared 16-bit free-running counter. It accepts one command at a time over a valid/ready handshake. Each command carries an on length, an off length and a repeat count. The block derives its time base from a selected bit of the counter, runs the on/off/repeat state machine, and reports busy and completion. It sits in `tt_um_mrmola` between `counter` and the `uo_out` LED pin, and replaces free-running blinking with commanded patterns.

## Interface
Parameters:
- `TICK_BIT`, default 10: index of the `current_count` bit whose rising edge is one tick.
- `LEN_W`, default 8: width of the on and off lengths, in ticks.
- `REP_W`, default 4: width of the repeat count.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `ena`  in  1: design enable. While low, ticks are ignored and no command is accepted.
- `current_count`  in  16: value of the shared `counter` output.
- `cmd_valid`  in  1: a command is offered.
- `cmd_ready`  out  1: the block can accept a command.
- `cmd_on`  in  LEN_W: on-phase length in ticks.
- `cmd_off`  in  LEN_W: off-phase length in ticks.
- `cmd_reps`  in  REP_W: number of on/off repetitions.
- `abort`  in  1: cancel the command in progress.
- `blink_out`  out  1: LED drive.
- `busy`  out  1: a command is executing.
- `done`  out  1: one-cycle pulse when a command completes normally.

## Operation
- Tick: `tick = ena & current_count[TICK_BIT] & ~prev_bit`. `prev_bit` is registered every cycle and resets to 0.
- `cmd_ready = rst_n & ena & ~abort & (state == IDLE)`. It is combinational.
- A command is accepted when `cmd_valid & cmd_ready` at a clock edge. The edge latches `on_len`, `off_len` and `reps`, and clears `phase_cnt` and `rep_cnt`.
- Length clamp: `cmd_on == 0` is treated as 1; `cmd_off == 0` is treated as 1.
- `cmd_reps == 0`: the command is accepted, the state stays IDLE, no blink occurs, and `done` pulses in the next cycle.
- States:
  - IDLE: `blink_out = 0`, `busy = 0`. On accept with `reps != 0`, go to ON.
  - ON: `blink_out = 1`. On each tick, `phase_cnt++`. On the tick where `phase_cnt == on_len-1`, go to OFF and set `phase_cnt = 0`.
  - OFF: `blink_out = 0`. On each tick, `phase_cnt++`. On the tick where `phase_cnt == off_len-1`:
    - if `rep_cnt == reps-1`, go to IDLE and pulse `done`;
    - otherwise `rep_cnt++`, `phase_cnt = 0`, and go to ON.
- `abort` is sampled at a clock edge. From any state it forces IDLE and clears the counters, with no `done` pulse. If `abort` and `cmd_valid` are asserted in the same cycle, the command is not accepted.
- `ena` low freezes the state and counters. Outputs hold their values.

## Timing
- During reset (`rst_n` low at an edge), outputs take these values from the next cycle: `blink_out = 0`, `busy = 0`, `done = 0`, state IDLE, all counters 0, `prev_bit = 0`. `cmd_ready` is 0 while `rst_n` is low.
- Reset asserted mid-command has the same effect as `abort`: no `done` pulse.
- `blink_out`, `busy` and `done` are registered.
- Accept at edge N: `blink_out = 1` and `busy = 1` from cycle N+1.
- A tick in the same cycle as the accept is not counted.
- Each phase ends on the Nth tick counted after the phase is entered. The first ON phase may therefore be shorter than the nominal period by up to one tick.
- Final OFF tick at edge M: in cycle M+1, `done = 1`, `busy = 0` and `cmd_ready = 1`. A back-to-back command can be accepted at edge M+1.
- `done` is high for exactly one cycle per normally completed command.
- The counter wrapping from 0xFFFF to 0 gives no extra tick unless it produces a real rising edge on `TICK_BIT`.

## Structure
- Shared package `blink_pkg`:
  - state enum `blink_state_t` with values IDLE, ON, OFF;
  - default constants `TICK_BIT_DEF`, `LEN_W_DEF`, `REP_W_DEF`.
- Sub-module `tick_gen`: holds the `prev_bit` register and produces the gated rising-edge strobe. Parameter `TICK_BIT`; ports `clk`, `rst_n`, `ena`, `current_count`, `tick`.
- The top-level sequencer holds the FSM, the latched command fields, `phase_cnt`, `rep_cnt` and the output registers.

## Test plan
All scenarios use `TICK_BIT = 0` with `counter` incrementing every cycle, so one tick occurs every 2 cycles.
- Basic command: accept `on = 2`, `off = 3`, `reps = 2`. Required: `blink_out` follows high 2 ticks / low 3 ticks, twice. `done` is a single-cycle pulse after the 10th counted tick. `busy` falls in the same cycle as `done`.
- Reset mid-ON: apply `rst_n` low at a mid-ON edge. Required: next cycle `blink_out = 0`, `busy = 0`, `done` never pulses. After release, `cmd_ready = 1` with `ena = 1`.
- `reps = 0`: accept `on = 5`, `off = 5`, `reps = 0`. Required: `blink_out` stays 0 and `done` pulses in the cycle after accept.
- Zero lengths: accept `on = 0`, `off = 0`, `reps = 3`. Required: behaviour identical to `on = 1`, `off = 1`, with 6 ticks total before `done`.
- Abort collision: assert `abort` during OFF, with `cmd_valid` high in the same cycle. Required: IDLE next cycle, no `done`, command not accepted. The command is accepted on the following cycle.
- `ena` and back-to-back: drop `ena` for 20 cycles mid-ON. Required: `blink_out` holds and the phase resumes with the tick count preserved. Then present a second command in the `done` cycle. Required: it is accepted with zero gap cycles.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and default parameters for the blink sequencer.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    localparam int unsigned TICK_BIT_DEF = 10;
    localparam int unsigned LEN_W_DEF    = 8;
    localparam int unsigned REP_W_DEF    = 4;

endpackage

// File: rtl/tick_gen.sv
// Rising-edge strobe on one bit of the shared free-running counter, gated by ena.
module tick_gen
    import blink_pkg::*;
#(
    parameter int unsigned TICK_BIT = TICK_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [15:0] current_count,
    output logic        tick
);

    logic prev_bit_q;
    logic unused_count;

    // Only one bit is sampled; the reduction keeps the rest of the bus visibly consumed.
    assign unused_count = ^current_count;

    // prev_bit tracks the counter bit every cycle, even while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_bit_q <= 1'b0;
        end else begin
            prev_bit_q <= current_count[TICK_BIT];
        end
    end

    assign tick = ena & current_count[TICK_BIT] & ~prev_bit_q;

endmodule

// File: rtl/blink_sequencer.sv
// Commanded on/off/repeat blink controller timed by ticks derived from the shared counter.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int unsigned TICK_BIT = TICK_BIT_DEF,
    parameter int unsigned LEN_W    = LEN_W_DEF,
    parameter int unsigned REP_W    = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [15:0]      current_count,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_on,
    input  logic [LEN_W-1:0] cmd_off,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             blink_out,
    output logic             busy,
    output logic             done
);

    blink_state_t     state_q, state_d;
    logic [LEN_W-1:0] on_len_q, on_len_d;
    logic [LEN_W-1:0] off_len_q, off_len_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    logic blink_q, blink_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic done_evt;
    logic tick;
    logic accept;

    tick_gen #(
        .TICK_BIT (TICK_BIT)
    ) u_tick_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .current_count (current_count),
        .tick          (tick)
    );

    assign cmd_ready = rst_n & ena & ~abort & (state_q == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            on_len_q  <= '0;
            off_len_q <= '0;
            phase_q   <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            phase_q   <= phase_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Tick already carries ena, so with ena low only abort can move the FSM.
    always_comb begin
        state_d   = state_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        phase_d   = phase_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        done_evt  = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            phase_d   = '0;
            rep_cnt_d = '0;
        end else if (accept) begin
            on_len_d  = (cmd_on == '0) ? LEN_W'(1) : cmd_on;
            off_len_d = (cmd_off == '0) ? LEN_W'(1) : cmd_off;
            reps_d    = cmd_reps;
            phase_d   = '0;
            rep_cnt_d = '0;
            if (cmd_reps == '0) begin
                done_evt = 1'b1;
            end else begin
                state_d = ON;
            end
        end else if (tick) begin
            unique case (state_q)
                ON: begin
                    if (phase_q == on_len_q - LEN_W'(1)) begin
                        state_d = OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + LEN_W'(1);
                    end
                end
                OFF: begin
                    if (phase_q == off_len_q - LEN_W'(1)) begin
                        phase_d = '0;
                        if (rep_cnt_q == reps_q - REP_W'(1)) begin
                            state_d   = IDLE;
                            rep_cnt_d = '0;
                            done_evt  = 1'b1;
                        end else begin
                            state_d   = ON;
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        blink_d = (state_d == ON);
        busy_d  = (state_d != IDLE);
        done_d  = done_evt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            blink_q <= blink_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign blink_out = blink_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
